// File: rtl/memory_master.sv
// Command-register bus initiator: the CPU loads request fields and TRY_* commands through `in`, reads status/data on `out`.
// Optional bus-wait abort enabled by defining MEMORY_MASTER_TIMEOUT_EN.
module memory_master #(
   parameter int ADDR_W         = 24,
   parameter int DATA_W         = 24,
   parameter int ID_W           = 8,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [31:0]       in,
   output logic [31:0]       out,
   output logic              msValid,
   input  logic              msTaken,
   output logic [ADDR_W-1:0] msAddress,
   output logic [DATA_W-1:0] msData,
   output logic              msWrite,
   output logic [ID_W-1:0]   msID,
   input  logic              smValid,
   output logic              smTake,
   input  logic              smTaken,
   input  logic [DATA_W-1:0] smData,
   input  logic [ID_W-1:0]   smID
);

   localparam logic [7:0] CMD_NONE        = 8'd0;
   localparam logic [7:0] CMD_ADDRESS     = 8'd1;
   localparam logic [7:0] CMD_DATA        = 8'd2;
   localparam logic [7:0] CMD_WRITE       = 8'd3;
   localparam logic [7:0] CMD_MASTER_ID   = 8'd4;
   localparam logic [7:0] CMD_TRY_SEND    = 8'd5;
   localparam logic [7:0] CMD_TRY_TAKE    = 8'd6;
   localparam logic [7:0] CMD_READ_DATA   = 8'd7;
   localparam logic [7:0] CMD_READ_ID     = 8'd8;
   localparam logic [7:0] CMD_READ_STATUS = 8'd9;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1, S_TAKE = 2'd2, S_WAIT = 2'd3} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              write_q, write_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [ID_W-1:0]   rid_q, rid_d;
   logic              err_q;

   logic [7:0]  cmd;
   logic [23:0] field;
   logic        cmd_is_none;

   assign cmd   = in[31:24];
   assign field = in[23:0];
   // Unknown command codes release WAIT exactly like NONE.
   assign cmd_is_none = (cmd == CMD_NONE) || (cmd > CMD_READ_STATUS);

`ifdef MEMORY_MASTER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_d;
   logic             timeout_hit;

   assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end
`else
   assign err_q = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         write_q <= 1'b0;
         id_q    <= '0;
         rdata_q <= '0;
         rid_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         write_q <= write_d;
         id_q    <= id_d;
         rdata_q <= rdata_d;
         rid_q   <= rid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      write_d = write_q;
      id_d    = id_q;
      rdata_d = rdata_q;
      rid_d   = rid_q;
`ifdef MEMORY_MASTER_TIMEOUT_EN
      cnt_d   = cnt_q;
      err_d   = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            case (cmd)
               CMD_ADDRESS:   addr_d  = field[ADDR_W-1:0];
               CMD_DATA:      data_d  = field[DATA_W-1:0];
               CMD_WRITE:     write_d = field[0];
               CMD_MASTER_ID: id_d    = field[ID_W-1:0];
               CMD_TRY_SEND: begin
                  state_d = S_SEND;
`ifdef MEMORY_MASTER_TIMEOUT_EN
                  err_d   = 1'b0;
                  cnt_d   = '0;
`endif
               end
               CMD_TRY_TAKE: begin
                  state_d = S_TAKE;
`ifdef MEMORY_MASTER_TIMEOUT_EN
                  err_d   = 1'b0;
                  cnt_d   = '0;
`endif
               end
               default: ;
            endcase
         end
         S_SEND: begin
            // Completion is tested first so it wins over a same-cycle timeout.
            if (msTaken) state_d = S_WAIT;
`ifdef MEMORY_MASTER_TIMEOUT_EN
            else if (timeout_hit) begin
               err_d   = 1'b1;
               state_d = S_WAIT;
            end else cnt_d = cnt_q + CNT_W'(1);
`endif
         end
         S_TAKE: begin
            if (smValid && smTaken) begin
               rdata_d = smData;
               rid_d   = smID;
               state_d = S_WAIT;
            end
`ifdef MEMORY_MASTER_TIMEOUT_EN
            else if (timeout_hit) begin
               err_d   = 1'b1;
               state_d = S_WAIT;
            end else cnt_d = cnt_q + CNT_W'(1);
`endif
         end
         S_WAIT: begin
            if (cmd_is_none) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      out = 32'h0;
      case (cmd)
         CMD_TRY_SEND, CMD_TRY_TAKE: out = 32'(state_q == S_WAIT);
         CMD_READ_DATA:              out = 32'(rdata_q);
         CMD_READ_ID:                out = 32'(rid_q);
         CMD_READ_STATUS:            out = {29'b0, err_q, state_q};
         default:                    out = 32'h0;
      endcase
   end

   // Bus strobes depend on state only, so nothing on `in` reaches the bus combinationally.
   assign msValid   = (state_q == S_SEND);
   assign smTake    = (state_q == S_TAKE);
   assign msAddress = addr_q;
   assign msData    = data_q;
   assign msWrite   = write_q;
   assign msID      = id_q;

endmodule

// File: tb/tb_memory_master.sv
// Directed bench for memory_master: table of per-cycle vectors plus hand sequences for hold, reset and timeout cases.
module tb_memory_master;

`ifdef MEMORY_MASTER_TIMEOUT_EN
   localparam int TO = 8;
`else
   localparam int TO = 1023;
`endif

   logic        clock;
   logic        reset;
   logic [31:0] in_w;
   logic [31:0] out_w;
   logic        ms_valid;
   logic        ms_taken;
   logic [23:0] ms_address;
   logic [23:0] ms_data;
   logic        ms_write;
   logic [7:0]  ms_id;
   logic        sm_valid;
   logic        sm_take;
   logic        sm_taken;
   logic [23:0] sm_data;
   logic [7:0]  sm_id;

   memory_master #(
      .ADDR_W(24), .DATA_W(24), .ID_W(8), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clock(clock), .reset(reset), .in(in_w), .out(out_w),
      .msValid(ms_valid), .msTaken(ms_taken), .msAddress(ms_address),
      .msData(ms_data), .msWrite(ms_write), .msID(ms_id),
      .smValid(sm_valid), .smTake(sm_take), .smTaken(sm_taken),
      .smData(sm_data), .smID(sm_id)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] word;
      logic        mt, sv, st;
      logic [23:0] sd;
      logic [7:0]  sid;
      logic [90:0] exp;
   } vec_t;

   vec_t        vecs[$];
   logic [90:0] exp_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;

   function automatic vec_t mk(input logic [31:0] w, input logic mt, input logic sv, input logic st,
                               input logic [23:0] sd, input logic [7:0] sid, input logic [31:0] eo,
                               input logic emv, input logic est, input logic [23:0] ea,
                               input logic [23:0] ed, input logic ew, input logic [7:0] ei);
      vec_t r;
      r.word = w; r.mt = mt; r.sv = sv; r.st = st; r.sd = sd; r.sid = sid;
      r.exp  = {eo, emv, est, ea, ed, ew, ei};
      return r;
   endfunction

   // driver tasks
   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic drive(input logic [31:0] w, input logic mt, input logic sv, input logic st,
                        input logic [23:0] sd, input logic [7:0] sid);
      in_w = w; ms_taken = mt; sm_valid = sv; sm_taken = st; sm_data = sd; sm_id = sid;
   endtask

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [90:0] snap();
      return {out_w, ms_valid, sm_take, ms_address, ms_data, ms_write, ms_id};
   endfunction

   initial begin
      logic [23:0] A;
      logic [23:0] D;
      int          xfers;
      A = 24'h001234;
      D = 24'hABCDEF;

      reset = 1'b0;
      drive(32'h0, 0, 0, 0, 24'h0, 8'h0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;

      // write sequence, held TRY_SEND, response capture, unknown command releasing WAIT
      vecs.push_back(mk(32'h09000000, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(32'h01001234, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(32'h02ABCDEF, 0, 0, 0, 0, 0, 32'h0, 0, 0, A, 0, 0, 0));
      vecs.push_back(mk(32'h03000001, 0, 0, 0, 0, 0, 32'h0, 0, 0, A, D, 0, 0));
      vecs.push_back(mk(32'h04000005, 0, 0, 0, 0, 0, 32'h0, 0, 0, A, D, 1, 0));
      vecs.push_back(mk(32'h05000000, 0, 0, 0, 0, 0, 32'h0, 0, 0, A, D, 1, 5));
      vecs.push_back(mk(32'h05000000, 0, 0, 0, 0, 0, 32'h0, 1, 0, A, D, 1, 5));
      vecs.push_back(mk(32'h05000000, 0, 0, 0, 0, 0, 32'h0, 1, 0, A, D, 1, 5));
      vecs.push_back(mk(32'h05000000, 0, 0, 0, 0, 0, 32'h0, 1, 0, A, D, 1, 5));
      vecs.push_back(mk(32'h05000000, 1, 0, 0, 0, 0, 32'h0, 1, 0, A, D, 1, 5));
      vecs.push_back(mk(32'h05000000, 1, 0, 0, 0, 0, 32'h1, 0, 0, A, D, 1, 5));
      vecs.push_back(mk(32'h09000000, 0, 0, 0, 0, 0, 32'h3, 0, 0, A, D, 1, 5));
      vecs.push_back(mk(32'h02111111, 0, 0, 0, 0, 0, 32'h0, 0, 0, A, D, 1, 5));
      vecs.push_back(mk(32'h00000000, 0, 0, 0, 0, 0, 32'h0, 0, 0, A, D, 1, 5));
      vecs.push_back(mk(32'h09000000, 0, 0, 0, 0, 0, 32'h0, 0, 0, A, D, 1, 5));
      vecs.push_back(mk(32'h00000000, 0, 1, 1, 24'h00BEEF, 8'h05, 32'h0, 0, 0, A, D, 1, 5));
      vecs.push_back(mk(32'h06000000, 0, 1, 1, 24'h00BEEF, 8'h05, 32'h0, 0, 0, A, D, 1, 5));
      vecs.push_back(mk(32'h06000000, 0, 1, 1, 24'h00BEEF, 8'h05, 32'h0, 0, 1, A, D, 1, 5));
      vecs.push_back(mk(32'h06000000, 0, 0, 0, 0, 0, 32'h1, 0, 0, A, D, 1, 5));
      vecs.push_back(mk(32'h07000000, 0, 0, 0, 0, 0, 32'h0000BEEF, 0, 0, A, D, 1, 5));
      vecs.push_back(mk(32'h08000000, 0, 0, 0, 0, 0, 32'h00000005, 0, 0, A, D, 1, 5));
      vecs.push_back(mk(32'hFF000000, 0, 0, 0, 0, 0, 32'h0, 0, 0, A, D, 1, 5));
      vecs.push_back(mk(32'h09000000, 0, 0, 0, 0, 0, 32'h0, 0, 0, A, D, 1, 5));
      vecs.push_back(mk(32'h07000000, 0, 0, 0, 0, 0, 32'h0000BEEF, 0, 0, A, D, 1, 5));

      for (int i = 0; i < vecs.size(); i++) begin
         logic [90:0] e;
         drive(vecs[i].word, vecs[i].mt, vecs[i].sv, vecs[i].st, vecs[i].sd, vecs[i].sid);
         exp_q.push_back(vecs[i].exp);
         #1;
         e = exp_q.pop_front();
         check($sformatf("row%0d", i), 96'(snap()), 96'(e));
         step();
      end

      // held TRY_SEND with msTaken high: one transfer only, then parked in WAIT
      drive(32'h05000000, 1, 0, 0, 0, 0);
      xfers = 0;
      for (int i = 0; i < 12; i++) begin
         #1;
         if (ms_valid && ms_taken) xfers++;
         step();
      end
      check("hold_xfers", 96'(xfers), 96'd1);
      drive(32'h09000000, 0, 0, 0, 0, 0);
      #1 check("hold_status_wait", 96'(out_w), 96'h3);
      drive(32'h00000000, 0, 0, 0, 0, 0);
      step();
      drive(32'h09000000, 0, 0, 0, 0, 0);
      #1 check("hold_status_idle", 96'(out_w), 96'h0);
      step();

      // DATA load attempted while SEND is pending
      drive(32'h05000000, 0, 0, 0, 0, 0);
      step();
      drive(32'h02111111, 0, 0, 0, 0, 0);
      #1 check("send_data_hold0", 96'({ms_valid, ms_data}), 96'({1'b1, D}));
      step();
      #1 check("send_data_hold1", 96'({ms_valid, ms_data}), 96'({1'b1, D}));

      // asynchronous reset in the middle of SEND
      #2 reset = 1'b0;
      #1 check("rst_bus", 96'({ms_valid, sm_take, ms_address, ms_data, ms_write, ms_id}), 96'h0);
      drive(32'h09000000, 0, 0, 0, 0, 0);
      #1 check("rst_status", 96'(out_w), 96'h0);
      drive(32'h07000000, 0, 0, 0, 0, 0);
      #1 check("rst_rdata", 96'(out_w), 96'h0);
      drive(32'h08000000, 0, 0, 0, 0, 0);
      #1 check("rst_rid", 96'(out_w), 96'h0);
      @(negedge clock);
      reset = 1'b1;
      drive(32'h0, 0, 0, 0, 0, 0);
      step();

`ifdef MEMORY_MASTER_TIMEOUT_EN
      // completion on the timeout cycle wins
      drive(32'h06000000, 0, 0, 0, 0, 0);
      step();
      for (int k = 1; k < TO; k++) begin
         #1 check($sformatf("to_a_take%0d", k), 96'(sm_take), 96'd1);
         step();
      end
      drive(32'h06000000, 0, 1, 1, 24'h123456, 8'h33);
      #1 check("to_a_take_last", 96'(sm_take), 96'd1);
      step();
      drive(32'h09000000, 0, 0, 0, 0, 0);
      #1 check("to_a_status", 96'(out_w), 96'h3);
      drive(32'h07000000, 0, 0, 0, 0, 0);
      #1 check("to_a_rdata", 96'(out_w), 96'h123456);
      drive(32'h00000000, 0, 0, 0, 0, 0);
      step();

      // no response at all: abort after TO cycles, no capture
      drive(32'h06000000, 0, 0, 0, 0, 0);
      step();
      for (int k = 1; k <= TO; k++) begin
         #1 check($sformatf("to_b_take%0d", k), 96'(sm_take), 96'd1);
         step();
      end
      drive(32'h09000000, 0, 0, 0, 0, 0);
      #1 check("to_b_status", 96'({sm_take, out_w}), 96'h7);
      drive(32'h07000000, 0, 0, 0, 0, 0);
      #1 check("to_b_rdata", 96'(out_w), 96'h123456);
      drive(32'h00000000, 0, 0, 0, 0, 0);
      step();
      drive(32'h09000000, 0, 0, 0, 0, 0);
      #1 check("to_b_err_idle", 96'(out_w), 96'h4);
      drive(32'h06000000, 0, 0, 0, 0, 0);
      step();
      drive(32'h09000000, 0, 0, 0, 0, 0);
      #1 check("to_b_err_clear", 96'(out_w), 96'h2);
      step();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
